// File: rtl/matrix_column_scanner_pkg.sv
// matrix_pkg: shared types and constants for the 5x7 LED matrix column scanner.
//   state_t    - scanner FSM states (S_IDLE, S_LOAD, S_SHOW, S_BLANK)
//   N_COLS     - physical columns on the matrix
//   N_ROWS     - rows per column (bit 6 = top row)
//   LAST_COL   - index of the final column in a frame
//   col_source - which source image (2 = col_2, 1 = col_1, 0 = col_0) feeds a column
package matrix_pkg;

    localparam int N_COLS = 5;
    localparam int N_ROWS = 7;
    localparam logic [2:0] LAST_COL = 3'd4;

    // Prefixed so the BLANK state cannot collide with the BLANK timing parameter.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHOW  = 2'd2,
        S_BLANK = 2'd3
    } state_t;

    // Mirror-symmetric mapping: outer columns share col_2, inner pair shares col_1.
    function automatic logic [1:0] col_source(input logic [2:0] col_idx);
        case (col_idx)
            3'd0, 3'd4: col_source = 2'd2;
            3'd1, 3'd3: col_source = 2'd1;
            default:    col_source = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/matrix_column_scanner_if.sv
// matrix_column_scanner_if: signal bundle between the image decoders, the
// scanner and the LED matrix pins.
//   enable      - 1 = scan, 0 = blank and idle
//   col_2..0    - source column images (bit 6 = top row)
//   brightness  - dimming level, present only with MATRIX_DIMMING_EN
//   matrix_col  - column select pins (polarity set by OUT_ACTIVE_LOW)
//   matrix_row  - row data pins (polarity set by OUT_ACTIVE_LOW)
//   scan_col    - index of the column being shown, 0 outside SHOW
//   frame_done  - one-cycle pulse after each complete frame
//   state       - debug view of the scanner FSM
// Bus contract: there is no valid/ready pair. The image inputs are level
// signals that the scanner samples only in its LOAD cycle; the master may
// change them at any time and the change takes effect from the next frame.
// All outputs are registered and change only on the rising clock edge.
interface matrix_column_scanner_if;
    import matrix_pkg::*;

    logic              enable;
    logic [N_ROWS-1:0] col_2;
    logic [N_ROWS-1:0] col_1;
    logic [N_ROWS-1:0] col_0;
`ifdef MATRIX_DIMMING_EN
    logic [1:0]        brightness;
`endif
    logic [N_COLS-1:0] matrix_col;
    logic [N_ROWS-1:0] matrix_row;
    logic [2:0]        scan_col;
    logic              frame_done;
    state_t            state;

`ifdef MATRIX_DIMMING_EN
    modport master (output enable, col_2, col_1, col_0, brightness,
                    input  matrix_col, matrix_row, scan_col, frame_done, state);
    modport slave  (input  enable, col_2, col_1, col_0, brightness,
                    output matrix_col, matrix_row, scan_col, frame_done, state);
`else
    modport master (output enable, col_2, col_1, col_0,
                    input  matrix_col, matrix_row, scan_col, frame_done, state);
    modport slave  (input  enable, col_2, col_1, col_0,
                    output matrix_col, matrix_row, scan_col, frame_done, state);
`endif

endinterface

// File: rtl/matrix_column_scanner_dwell_timer.sv
// matrix_dwell_timer: loadable down-counter shared by the SHOW and BLANK
// states. Loading N-1 makes done assert on the N-th cycle after the load.
//   clock, reset_n - clock and synchronous active-low reset
//   load           - load load_value on the next edge
//   load_value     - cycles-minus-one to time
//   count_next     - value the counter takes on the next edge
//                    (only with MATRIX_DIMMING_EN, used for row gating)
//   done           - current count is zero (last cycle of the period)
module matrix_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
`ifdef MATRIX_DIMMING_EN
    output logic [W-1:0] count_next,
`endif
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] next_value;

    // Holds at zero once expired so an idle timer stays quiet.
    always_comb begin
        next_value = count_q;
        if (load) begin
            next_value = load_value;
        end else if (count_q != '0) begin
            next_value = count_q - W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= next_value;
        end
    end

    assign done = (count_q == '0);

`ifdef MATRIX_DIMMING_EN
    assign count_next = next_value;
`endif

endmodule

// File: rtl/matrix_column_scanner.sv
// matrix_column_scanner: time-multiplexes three mirror-symmetric column
// images onto a 5x7 LED matrix, one column at a time, with a dwell period
// per column and a blanking gap between columns. The image is captured once
// per frame in LOAD so a mid-frame input change never tears the display.
//   clock   - system clock, rising edge
//   reset_n - synchronous active-low reset
//   bus     - matrix_column_scanner_if.slave (enable, images, LED pins,
//             scan_col, frame_done, debug state)
// Parameters: DWELL (cycles per lit column, >= 1), BLANK (off cycles between
// columns, 0 removes the gap), OUT_ACTIVE_LOW (invert the LED pins).
// Optional build macro: MATRIX_DIMMING_EN adds bus.brightness, which limits
// how much of each dwell the rows are driven.
module matrix_column_scanner
    import matrix_pkg::*;
#(
    parameter int DWELL          = 1000,
    parameter int BLANK          = 4,
    parameter bit OUT_ACTIVE_LOW = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    matrix_column_scanner_if.slave  bus
);

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

    state_t                  state_q, state_n;
    logic [2:0]              col_q, col_n;
    logic [2:0][N_ROWS-1:0]  frame_q, frame_n;
    logic                    timer_load;
    logic [CNT_W-1:0]        timer_value;
    logic                    timer_done;
    logic                    frame_end;

    // Logical (active-high) output registers, inverted at the pins if needed.
    logic [N_COLS-1:0]       col_sel_q, col_sel_n;
    logic [N_ROWS-1:0]       row_q, row_n;
    logic [2:0]              scan_q, scan_n;
    logic                    done_q;
    logic [N_ROWS-1:0]       image;
    logic                    row_on;

`ifdef MATRIX_DIMMING_EN
    logic [1:0]              bright_q, bright_n;
    logic [CNT_W-1:0]        cnt_next;
    int                      elapsed;
    int                      lit_cycles;
`endif

    matrix_dwell_timer #(.W(CNT_W)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
`ifdef MATRIX_DIMMING_EN
        .count_next (cnt_next),
`endif
        .done       (timer_done)
    );

    // Next-state logic. Outputs are registered from the *next* state so the
    // pins show a column in exactly the cycles the FSM is in SHOW.
    always_comb begin
        state_n     = state_q;
        col_n       = col_q;
        timer_load  = 1'b0;
        timer_value = DWELL_LOAD;
        frame_end   = 1'b0;
        frame_n     = frame_q;
        if (state_q == S_LOAD) begin
            frame_n = {bus.col_2, bus.col_1, bus.col_0};
        end

        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!bus.enable) begin
                    state_n = S_IDLE;
                end else begin
                    state_n    = S_SHOW;
                    col_n      = 3'd0;
                    timer_load = 1'b1;
                end
            end
            S_SHOW: begin
                if (!bus.enable) begin
                    state_n = S_IDLE;
                end else if (timer_done) begin
                    if (BLANK > 0) begin
                        state_n     = S_BLANK;
                        timer_load  = 1'b1;
                        timer_value = BLANK_LOAD;
                    end else if (col_q < LAST_COL) begin
                        state_n    = S_SHOW;
                        col_n      = col_q + 3'd1;
                        timer_load = 1'b1;
                    end else begin
                        state_n   = S_LOAD;
                        frame_end = 1'b1;
                    end
                end
            end
            S_BLANK: begin
                if (!bus.enable) begin
                    state_n = S_IDLE;
                end else if (timer_done) begin
                    if (col_q < LAST_COL) begin
                        state_n    = S_SHOW;
                        col_n      = col_q + 3'd1;
                        timer_load = 1'b1;
                    end else begin
                        state_n   = S_LOAD;
                        frame_end = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Source image for the column about to be shown.
    always_comb begin
        case (col_source(col_n))
            2'd2:    image = frame_n[2];
            2'd1:    image = frame_n[1];
            default: image = frame_n[0];
        endcase
    end

`ifdef MATRIX_DIMMING_EN
    // Rows are lit for the first ((brightness+1)*DWELL)/4 cycles of a dwell;
    // the down-counter is converted back to cycles elapsed since SHOW entry.
    always_comb begin
        bright_n = bright_q;
        if (state_q == S_LOAD) begin
            bright_n = bus.brightness;
        end
        elapsed    = DWELL - 1 - int'(cnt_next);
        lit_cycles = ((int'(bright_n) + 1) * DWELL) / 4;
        row_on     = (elapsed < lit_cycles);
    end
`else
    assign row_on = 1'b1;
`endif

    always_comb begin
        col_sel_n = '0;
        row_n     = '0;
        scan_n    = 3'd0;
        if (state_n == S_SHOW) begin
            col_sel_n = N_COLS'(1) << col_n;
            row_n     = row_on ? image : '0;
            scan_n    = col_n;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            col_q     <= 3'd0;
            frame_q   <= '0;
            col_sel_q <= '0;
            row_q     <= '0;
            scan_q    <= 3'd0;
            done_q    <= 1'b0;
`ifdef MATRIX_DIMMING_EN
            bright_q  <= 2'd0;
`endif
        end else begin
            state_q   <= state_n;
            col_q     <= col_n;
            frame_q   <= frame_n;
            col_sel_q <= col_sel_n;
            row_q     <= row_n;
            scan_q    <= scan_n;
            done_q    <= frame_end;
`ifdef MATRIX_DIMMING_EN
            bright_q  <= bright_n;
`endif
        end
    end

    // Single pin-polarity stage.
    assign bus.matrix_col = OUT_ACTIVE_LOW ? ~col_sel_q : col_sel_q;
    assign bus.matrix_row = OUT_ACTIVE_LOW ? ~row_q : row_q;
    assign bus.scan_col   = scan_q;
    assign bus.frame_done = done_q;
    assign bus.state      = state_q;

endmodule
